// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties unless fetch has already waited out MAX_WAIT data grants.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              i_elig;
    logic              d_elig;
    logic              grant_i;
    logic              grant_d;

    // A port in its ready cycle is not eligible, so its next request
    // cannot be granted before the edge that ends the pulse.
    always_comb begin
        i_elig  = i_req & ~i_ready;
        d_elig  = d_req & ~d_ready;
        grant_d = (state == IDLE) & d_elig & (~i_elig | (wait_cnt != WAIT_MAX));
        grant_i = (state == IDLE) & i_elig & ~grant_d;
    end

    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            i_rdata   <= '0;
            i_ready   <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        if (i_req && (wait_cnt != WAIT_MAX))
                            wait_cnt <= wait_cnt + 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_byte  <= d_byte;
                        mem_wdata <= d_wdata;
                        mem_req   <= 1'b1;
                        state     <= BUSY_D;
                    end else if (grant_i) begin
                        wait_cnt  <= '0;
                        mem_addr  <= i_addr;
                        mem_we    <= 1'b0;
                        mem_byte  <= 1'b0;
                        mem_wdata <= '0;
                        mem_req   <= 1'b1;
                        state     <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        i_rdata <= mem_rdata;
                        i_ready <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        // Stores keep the last load value visible.
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                        d_ready <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// MAX_WAIT=1 so the fetch guard can actually be reached by legal requesters.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          i_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic          d_byte = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic          mem_byte;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_i_pulse = 0;
    int n_d_pulse = 0;

    // Reference model: one outstanding memory transaction, who owns it, and the
    // number of data grants fetch has sat through.
    bit            busy, busy_fetch;
    int            m_wait, ack_left, req_pct;
    bit            e_i_ready, e_d_ready, e_mem_req, e_mem_we, e_mem_byte;
    logic [DW-1:0] e_i_rdata, e_d_rdata, e_mem_wdata;
    logic [AW-1:0] e_mem_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0; busy_fetch = 0; m_wait = 0; ack_left = 0;
        e_i_ready = 0; e_d_ready = 0; e_mem_req = 0; e_mem_we = 0; e_mem_byte = 0;
        e_i_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
    endtask

    task automatic model_step();
        bit nir, ndr, ie, de, pick_fetch;
        if (!reset) begin
            model_reset();
            return;
        end
        nir = 0;
        ndr = 0;
        if (busy) begin
            if (mem_ack) begin
                if (busy_fetch) begin
                    e_i_rdata = mem_rdata;
                    nir = 1;
                end else begin
                    if (!e_mem_we) e_d_rdata = mem_rdata;
                    ndr = 1;
                end
                busy = 0;
                e_mem_req = 0;
            end
        end else begin
            ie = i_req && !e_i_ready;
            de = d_req && !e_d_ready;
            if (ie || de) begin
                pick_fetch = ie && (!de || m_wait == MW);
                if (pick_fetch) begin
                    m_wait = 0;
                    e_mem_addr = i_addr; e_mem_we = 0; e_mem_byte = 0; e_mem_wdata = '0;
                end else begin
                    if (i_req && m_wait < MW) m_wait++;
                    e_mem_addr = d_addr; e_mem_we = d_we; e_mem_byte = d_byte; e_mem_wdata = d_wdata;
                end
                busy = 1;
                busy_fetch = pick_fetch;
                e_mem_req = 1;
                ack_left = $urandom_range(0, 3);
            end
        end
        e_i_ready = nir;
        e_d_ready = ndr;
    endtask

    task automatic check_all();
        check("i_ready", i_ready, e_i_ready);
        check("d_ready", d_ready, e_d_ready);
        check("i_rdata", i_rdata, e_i_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("mem_req", mem_req, e_mem_req);
        check("mem_we", mem_we, e_mem_we);
        check("mem_byte", mem_byte, e_mem_byte);
        check("mem_addr", mem_addr, e_mem_addr);
        if (e_mem_we) check("mem_wdata", mem_wdata, e_mem_wdata);
        check("i_stall", i_stall, i_req && !e_i_ready);
        check("d_stall", d_stall, d_req && !d_ready_exp_helper());
        if (i_ready) n_i_pulse++;
        if (d_ready) n_d_pulse++;
    endtask

    function automatic bit d_ready_exp_helper();
        return e_d_ready;
    endfunction

    task automatic drive();
        if (!reset) begin
            // Release reset with a stale ack that must be ignored.
            reset = 1; i_req = 0; d_req = 0;
            mem_ack = 1; mem_rdata = $urandom;
            return;
        end
        if (!i_req || e_i_ready) begin
            i_req = ($urandom_range(0, 99) < req_pct);
            if (i_req) i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req || e_d_ready) begin
            d_req = ($urandom_range(0, 99) < req_pct);
            if (d_req) begin
                d_we = $urandom_range(0, 1); d_byte = $urandom_range(0, 1);
                d_addr = $urandom; d_wdata = $urandom;
            end
        end
        if (busy) begin
            if (ack_left == 0) begin
                mem_ack = 1; mem_rdata = $urandom;
            end else begin
                ack_left--; mem_ack = 0; mem_rdata = $urandom;
            end
        end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        model_reset();
        req_pct = 40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_all();
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            req_pct = (cyc < 1500) ? 40 : ((cyc < 3000) ? 90 : 60);
            @(negedge clock);
            check_all();
            drive();
            if (busy && reset && $urandom_range(0, 149) == 0) begin
                #2 reset = 0; i_req = 0; d_req = 0;
                #1 model_reset();
                check_all();
            end
            @(posedge clock);
            model_step();
        end
        check("i_progress", (n_i_pulse > 0), 1);
        check("d_progress", (n_d_pulse > 0), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
